// File: rtl/cp_remover_if.sv
// Stream bundle for the cyclic-prefix remover: CP+payload sample input on the
// s_* side, payload-only output with symbol markers on the m_* side.
interface cp_remover_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic              m_eof;

  // The block itself.
  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_sof, m_eof
  );

  // Upstream source plus downstream sink, seen as one party.
  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_sof, m_eof
  );
endinterface

// File: rtl/cp_remover.sv
// Cyclic-prefix remover: drops cp_length prefix samples of each symbol and
// forwards the frame_length payload samples with start/end-of-symbol markers.
module cp_remover #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  cp_remover_if.slave      bus,
  input  logic [LEN_W-1:0] cp_length,
  input  logic [LEN_W-1:0] frame_length,
  output logic             cfg_error,
  output logic [15:0]      sym_count
);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    PASS
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cp_l;
  logic [LEN_W-1:0] fr_l;
  logic [LEN_W-1:0] count;
  logic             in_beat;
  logic             cfg_ok;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.s_ready = 1'b0;
    case (state)
      SKIP:    bus.s_ready = 1'b1;
      PASS:    bus.s_ready = !bus.m_valid || bus.m_ready;
      default: bus.s_ready = 1'b0;
    endcase
  end

  assign in_beat = bus.s_valid && bus.s_ready;
  assign cfg_ok  = (frame_length != '0) && (cp_length <= frame_length);

  // NOTE: all state is updated with non-blocking assignments in one clocked
  // process with asynchronous reset, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cp_l        <= '0;
      fr_l        <= '0;
      count       <= '0;
      bus.m_data  <= '0;
      bus.m_valid <= 1'b0;
      bus.m_sof   <= 1'b0;
      bus.m_eof   <= 1'b0;
      cfg_error   <= 1'b0;
      sym_count   <= '0;
    end else begin
      // A delivered sample empties the output register unless refilled below.
      if (bus.m_valid && bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!cfg_ok) begin
            cfg_error <= 1'b1;
          end else begin
            cp_l  <= cp_length;
            fr_l  <= frame_length;
            count <= '0;
            state <= (cp_length != '0) ? SKIP : PASS;
          end
        end

        SKIP: begin
          if (in_beat) begin
            if (count == cp_l - LEN_W'(1)) begin
              count <= '0;
              state <= PASS;
            end else begin
              count <= count + LEN_W'(1);
            end
          end
        end

        PASS: begin
          if (in_beat) begin
            bus.m_data  <= bus.s_data;
            bus.m_valid <= 1'b1;
            bus.m_sof   <= (count == '0);
            bus.m_eof   <= (count == fr_l - LEN_W'(1));
            if (count == fr_l - LEN_W'(1)) begin
              count     <= '0;
              sym_count <= sym_count + 16'd1;
              state     <= IDLE;
            end else begin
              count <= count + LEN_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cp_remover.md
Name: cp_remover

Overview:
Receive-side companion to the cyclic-prefix inserter. It consumes a continuous stream of symbols, each made of cp_length prefix samples followed by frame_length payload samples. It discards the prefix and forwards the payload with start/end-of-symbol markers, using a valid/ready handshake on both sides. It sits directly downstream of the CP insertion stage, in loopback and receive paths, ahead of the FFT/sink.

Parameters:
DATA_W, 32, sample width in bits
LEN_W, 6, width of cp_length/frame_length and internal counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_data  input  DATA_W  input sample (CP + payload stream)
s_valid  input  1  s_data valid
s_ready  output  1  block accepts s_data this cycle
cp_length  input  LEN_W  prefix samples per symbol; sampled at symbol start
frame_length  input  LEN_W  payload samples per symbol; sampled at symbol start
m_data  output  DATA_W  payload sample out (registered)
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts m_data
m_sof  output  1  qualifies m_data as first payload sample of a symbol
m_eof  output  1  qualifies m_data as last payload sample of a symbol
cfg_error  output  1  sticky: illegal configuration seen
sym_count  output  16  symbols completed, wraps at 0xFFFF

Behaviour:
- Reset (async, rst_n=0): state=IDLE, s_ready=0, m_valid=0, m_data=0, m_sof=0, m_eof=0, cfg_error=0, sym_count=0, counters=0. Assert anywhere mid-symbol: the partial symbol is abandoned. After release, the next accepted sample is treated as the first CP sample.
- Transfer rule: input beat = s_valid & s_ready. Output beat = m_valid & m_ready.
- Config check in IDLE. Legal iff frame_length != 0 and cp_length <= frame_length.
  - Illegal: cfg_error<=1, stay IDLE, s_ready=0.
  - cfg_error clears only on reset.
- IDLE: latch cfg (cp_l, fr_l), clear count.
  - Next state SKIP if cp_l != 0, else PASS. One cycle; no sample consumed in IDLE.
- SKIP: s_ready=1 unconditionally. Each input beat discards the sample and increments count.
  - On the beat where count == cp_l-1: count<=0, go PASS.
- PASS: s_ready = !m_valid | m_ready (single output register, no bubble under continuous flow).
  - Each input beat: m_data<=s_data, m_valid<=1, m_sof<=(count==0), m_eof<=(count==fr_l-1), count++.
  - On the beat with count==fr_l-1: sym_count++, go IDLE.
  - Output beat with no new input beat: m_valid<=0.
- Latency: accepted payload sample appears on m_data the following cycle.
- Back-pressure: m_data/m_sof/m_eof hold stable while m_valid & !m_ready.
- Prefix samples are never back-pressured.
- Throughput: one IDLE cycle per symbol, so the maximum is (cp+fr)/(cp+fr+1) samples/cycle.
- cp_length/frame_length changes mid-symbol are ignored until the next IDLE.
- fr_l==1: the single payload sample carries m_sof=m_eof=1.
- Counters are LEN_W bits; max symbol = 63 CP + 63 payload.

Test Plan:
- cp=4, fr=8, s_valid=1 continuous, m_ready=1, data=0..23 → m_data 4..11 then 16..23; m_sof on 4 and 16; m_eof on 11 and 23; sym_count=2; samples 0-3 and 12-15 dropped.
- cp=0, fr=4, data=0..3 → all four forwarded, m_sof on 0, m_eof on 3, SKIP never entered.
- cp=2, fr=6, m_ready low for 3 cycles at payload sample 2 → m_data holds value 2 with m_valid=1; s_ready=0 during stall; no loss or duplication; sequence resumes 3..7.
- cp=5, fr=3 → cfg_error=1, s_ready=0, no m_valid. Reset then cp=1, fr=3 → normal operation, cfg_error=0.
- cp=3, fr=8, rst_n pulsed low after payload sample 2 → outputs clear immediately. The next stream is parsed from its first sample as CP; the first m_sof is on sample index 3.
- fr=1, cp=1, 4 symbols with s_valid toggling every cycle → one output per symbol with m_sof=m_eof=1; sym_count=4.
